// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the parametrised GPIO bank.
// Defaults match the legacy 8-pin bank with a two-flop synchroniser and no input filtering.
package gpio_pkg;

    localparam int DEF_WIDTH           = 8;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1;

    // Debounce counter width; never narrower than one bit so DEBOUNCE_CYCLES=1 still elaborates.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// Register-side signal bundle of the GPIO bank: drive/enable controls, pin readback and interrupts.
// The controller (CPU bus slave or FSM) takes the master view; the bank takes the slave view.
interface gpio_bank_if
    import gpio_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] dout_i;
    logic [WIDTH-1:0] oe_i;
    logic [WIDTH-1:0] din_o;
    logic [WIDTH-1:0] rise_en_i;
    logic [WIDTH-1:0] fall_en_i;
    logic [WIDTH-1:0] irq_clr_i;
    logic [WIDTH-1:0] irq_status_o;
    logic             irq_o;

    modport master (
        output dout_i, oe_i, rise_en_i, fall_en_i, irq_clr_i,
        input  din_o, irq_status_o, irq_o
    );

    modport slave (
        input  dout_i, oe_i, rise_en_i, fall_en_i, irq_clr_i,
        output din_o, irq_status_o, irq_o
    );

endinterface

// File: rtl/gpio_bit_filter.sv
// One pin's input conditioning: synchroniser chain, debounce counter, accepted level and edge detect.
// rise/fall are single-cycle pulses derived from the accepted (debounced) level only.
module gpio_bit_filter
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int            CW      = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   prev;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
        end
    end

    // A change is accepted only after s has disagreed with stable for DEBOUNCE_CYCLES evaluations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            prev   <= 1'b0;
        end else begin
            prev <= stable;
            if (s == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rise = stable & ~prev;
    assign fall = ~stable & prev;

endmodule

// File: rtl/gpio_bank.sv
// WIDTH-pin bidirectional GPIO bank: registered pad drive, per-pin filtered readback and
// sticky write-1-to-clear edge interrupts with a register-sourced irq line.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] dio_buf,
    gpio_bank_if.slave       bus
);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irq_status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            oe_q   <= '0;
        end else begin
            dout_q <= bus.dout_i;
            oe_q   <= bus.oe_i;
        end
    end

    // Readback taps the pad itself, so a driven pin observes its own value.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign dio_buf[i] = oe_q[i] ? dout_q[i] : 1'bz;

        gpio_bit_filter #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_filter (
            .clk    (clk),
            .rst_n  (rst_n),
            .pad    (dio_buf[i]),
            .stable (stable[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    // Set terms are OR-ed after the clear mask so a same-cycle event survives its clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~bus.irq_clr_i)
                        | (rise & bus.rise_en_i)
                        | (fall & bus.fall_en_i);
        end
    end

    assign bus.din_o        = stable;
    assign bus.irq_status_o = irq_status;
    assign bus.irq_o        = |irq_status;

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: two instances (no filtering and 4-cycle debounce) share stimulus and are
// checked every cycle against a pad-history model, plus directed literal checkpoints.
module tb_gpio_bank;
    import gpio_pkg::*;

    localparam int W     = 8;
    localparam int SYNC  = 2;
    localparam int DEB_A = 1;
    localparam int DEB_B = 4;
    localparam int HIST  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] dout, oe, rise_en, fall_en, irq_clr, tb_val, tb_en;
    wire  [W-1:0] pad_a, pad_b;

    gpio_bank_if #(.WIDTH(W)) bus_a ();
    gpio_bank_if #(.WIDTH(W)) bus_b ();

    assign bus_a.dout_i    = dout;
    assign bus_a.oe_i      = oe;
    assign bus_a.rise_en_i = rise_en;
    assign bus_a.fall_en_i = fall_en;
    assign bus_a.irq_clr_i = irq_clr;
    assign bus_b.dout_i    = dout;
    assign bus_b.oe_i      = oe;
    assign bus_b.rise_en_i = rise_en;
    assign bus_b.fall_en_i = fall_en;
    assign bus_b.irq_clr_i = irq_clr;

    for (genvar i = 0; i < W; i++) begin : g_ext
        assign pad_a[i] = tb_en[i] ? tb_val[i] : 1'bz;
        assign pad_b[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    gpio_bank #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .dio_buf(pad_a), .bus(bus_a)
    );
    gpio_bank #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .dio_buf(pad_b), .bus(bus_b)
    );

    // Model: registered drive, history of pad values seen at each edge, accepted level per instance.
    logic [W-1:0] m_oe, m_dout;
    logic [W-1:0] hist [HIST];
    logic [W-1:0] m_st [2];
    logic [W-1:0] m_pv [2];
    logic [W-1:0] m_stat [2];
    logic [W-1:0] m_pe, m_ns, m_rise, m_fall, c_pe;
    logic         all_diff;

    int total = 0;
    int bad   = 0;

    function automatic int deb_of(input int k);
        return (k == 0) ? DEB_A : DEB_B;
    endfunction

    function automatic logic [W-1:0] pad_exp();
        return (m_oe & m_dout) | (~m_oe & tb_val);
    endfunction

    task automatic model_reset();
        m_oe   = '0;
        m_dout = '0;
        for (int i = 0; i < HIST; i++) hist[i] = '0;
        for (int k = 0; k < 2; k++) begin
            m_st[k]   = '0;
            m_pv[k]   = '0;
            m_stat[k] = '0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // A pin's accepted level flips once its last DEB synchronised samples all disagree with it.
    initial forever begin
        @(posedge clk);
        if (rst_n) begin
            m_pe = pad_exp();
            for (int k = 0; k < 2; k++) begin
                m_ns = m_st[k];
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < deb_of(k); j++)
                        if (hist[SYNC-1+j][b] == m_st[k][b]) all_diff = 1'b0;
                    if (all_diff) m_ns[b] = ~m_st[k][b];
                end
                m_rise    = m_st[k] & ~m_pv[k];
                m_fall    = ~m_st[k] & m_pv[k];
                m_stat[k] = (m_stat[k] & ~irq_clr) | (m_rise & rise_en) | (m_fall & fall_en);
                m_pv[k]   = m_st[k];
                m_st[k]   = m_ns;
            end
            for (int i = HIST-1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = m_pe;
            m_oe    = oe;
            m_dout  = dout;
        end
        #1 tb_en = ~m_oe;
    end

    initial forever begin
        @(negedge clk);
        c_pe = pad_exp();
        chk("pad_a", pad_a, c_pe);
        chk("pad_b", pad_b, c_pe);
        chk("din_a", bus_a.din_o, m_st[0]);
        chk("din_b", bus_b.din_o, m_st[1]);
        chk("stat_a", bus_a.irq_status_o, m_stat[0]);
        chk("stat_b", bus_b.irq_status_o, m_stat[1]);
        chk("irq_a", bus_a.irq_o, |m_stat[0]);
        chk("irq_b", bus_b.irq_o, |m_stat[1]);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dout = '0; oe = '0; rise_en = '0; fall_en = '0; irq_clr = '0;
        tb_val = '0; tb_en = '1;
        rst_n = 1'b0;
        model_reset();
        tick(3);
        @(posedge clk); #3 rst_n = 1'b1;
        tick(2);
        chk("rst_din_a", bus_a.din_o, 8'h00);
        chk("rst_stat_b", bus_b.irq_status_o, 8'h00);

        // Drive and read back
        oe = 8'hFF; dout = 8'hA5;
        tick(1);
        chk("drv_pad_a", pad_a, 8'hA5);
        tick(2);
        chk("rb_early_a", bus_a.din_o, 8'h00);
        tick(1);
        chk("rb_a", bus_a.din_o, 8'hA5);
        tick(2);
        chk("rb_early_b", bus_b.din_o, 8'h00);
        tick(1);
        chk("rb_b", bus_b.din_o, 8'hA5);
        tb_val = '0; oe = '0;
        tick(10);

        // Debounce: 3-cycle glitch rejected, 4-cycle pulse accepted at edge 2+4
        tb_val = 8'h01;
        tick(3);
        tb_val = 8'h00;
        tick(10);
        chk("glitch_din_b", bus_b.din_o[0], 1'b0);
        chk("glitch_stat_b", bus_b.irq_status_o, 8'h00);
        tb_val = 8'h01;
        tick(4);
        tb_val = 8'h00;
        tick(1);
        chk("deb_pre_b", bus_b.din_o[0], 1'b0);
        tick(1);
        chk("deb_acc_b", bus_b.din_o[0], 1'b1);
        tick(10);

        // Edge interrupts
        tb_val = 8'h02;
        tick(10);
        rise_en = 8'h01; fall_en = 8'h02; irq_clr = 8'hFF;
        tick(1);
        irq_clr = 8'h00; tb_val = 8'h01;
        tick(3);
        chk("edge_pre_a", bus_a.irq_status_o, 8'h00);
        chk("irq_pre_a", bus_a.irq_o, 1'b0);
        tick(1);
        chk("edge_a", bus_a.irq_status_o, 8'h03);
        chk("irq_set_a", bus_a.irq_o, 1'b1);
        tick(2);
        chk("edge_pre_b", bus_b.irq_status_o, 8'h00);
        tick(1);
        chk("edge_b", bus_b.irq_status_o, 8'h03);
        tb_val = 8'h00;
        tick(10);
        chk("no_fall0_a", bus_a.irq_status_o, 8'h03);

        // Clear, and set winning over a simultaneous clear
        irq_clr = 8'h01;
        tick(1);
        irq_clr = 8'h00;
        chk("clr0_a", bus_a.irq_status_o, 8'h02);
        chk("clr0_b", bus_b.irq_status_o, 8'h02);
        tb_val = 8'h02;
        tick(10);
        tb_val = 8'h00;
        tick(3);
        irq_clr = 8'h02;
        tick(1);
        irq_clr = 8'h00;
        chk("setwins_a", bus_a.irq_status_o, 8'h02);
        tick(2);
        chk("clr1_b", bus_b.irq_status_o, 8'h00);
        tick(1);
        chk("fall1_b", bus_b.irq_status_o, 8'h02);

        // Disabling an enable keeps an already-set bit
        irq_clr = 8'hFF;
        tick(1);
        irq_clr = 8'h00;
        tb_val = 8'h01;
        tick(10);
        chk("rise0_a", bus_a.irq_status_o, 8'h01);
        rise_en = 8'h00;
        tick(3);
        chk("hold0_a", bus_a.irq_status_o, 8'h01);
        irq_clr = 8'h01;
        tick(1);
        irq_clr = 8'h00;
        chk("clrhold_a", bus_a.irq_status_o, 8'h00);
        chk("irq_clr_a", bus_a.irq_o, 1'b0);

        // Asynchronous reset mid-traffic with all pins driven
        oe = 8'hFF; dout = 8'h3C; tb_val = 8'h96;
        tick(3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        model_reset();
        tb_en = '1;
        #1;
        chk("rst_hiz_a", pad_a, 8'h96);
        chk("rst_din_b", bus_b.din_o, 8'h00);
        tick(2);
        @(posedge clk); #3 rst_n = 1'b1;
        #1 chk("rel_hiz_a", pad_a, 8'h96);
        tick(1);
        chk("rel_drv_a", pad_a, 8'h3C);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(15) == 0) oe = W'($urandom);
            if ($urandom_range(3) == 0) dout = W'($urandom);
            tb_val = tb_val ^ (W'($urandom) & W'($urandom) & W'($urandom));
            if ($urandom_range(31) == 0) rise_en = W'($urandom);
            if ($urandom_range(31) == 0) fall_en = W'($urandom);
            irq_clr = ($urandom_range(7) == 0) ? W'($urandom) : '0;
            if ($urandom_range(499) == 0) begin
                @(posedge clk); #3;
                rst_n = 1'b0;
                model_reset();
                tb_en = '1;
                tick(2);
                @(posedge clk); #3 rst_n = 1'b1;
            end
            tick(1);
        end

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised bidirectional GPIO bank: generalises the fixed 8-bit, single-direction-control GPIO to WIDTH pins with per-bit direction, registered pad drive, metastability-safe input synchronisation, per-bit debounce, and edge-triggered sticky interrupts. Sits between the top-level inout pads and the register/control logic (CPU bus slave or FSM) that reads pin state and services pin-change interrupts.

## Interface
- WIDTH, 8, number of pins
- SYNC_STAGES, 2, input synchroniser depth (>= 2)
- DEBOUNCE_CYCLES, 1, consecutive stable cycles required to accept an input change (>= 1; 1 = no filtering)

- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- dio_buf  inout  WIDTH  external pads
- dout_i  in  WIDTH  value to drive on pads
- oe_i  in  WIDTH  per-bit output enable, 1 = drive, 0 = high-Z
- din_o  out  WIDTH  synchronised, debounced pad value
- rise_en_i  in  WIDTH  per-bit rising-edge interrupt enable
- fall_en_i  in  WIDTH  per-bit falling-edge interrupt enable
- irq_clr_i  in  WIDTH  write-1-to-clear pulse for irq_status_o bits
- irq_status_o  out  WIDTH  sticky per-bit edge-event flags
- irq_o  out  1  OR-reduction of irq_status_o

## Operation
- Output path: dout_i, oe_i registered (dout_q, oe_q) each cycle; one IOBUF per bit, T = ~oe_q[i], I = dout_q[i].
- Input path per bit: IOBUF O -> SYNC_STAGES flop chain -> s.
- Debounce per bit, counter cnt of width max(1, clog2(DEBOUNCE_CYCLES)):
  - s == stable: cnt <= 0.
  - s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s, cnt <= 0.
  - otherwise cnt <= cnt+1. Glitch shorter than DEBOUNCE_CYCLES never reaches stable.
- din_o = stable. prev <= stable every cycle; rise = stable & ~prev, fall = ~stable & prev.
- Status: irq_status <= (irq_status & ~irq_clr_i) | (rise & rise_en_i) | (fall & fall_en_i). Set wins over simultaneous clear on the same bit.
- Enables gate setting only; disabling an enable does not clear an already-set status bit.
- Input path samples pads regardless of oe_q: a driven pin reads back its own value and raises edges if enabled.
- irq_o combinational OR of irq_status register (glitch-free, register-sourced).

## Timing
- Reset (rst_n low, async): dout_q=0, oe_q=0 (all pads high-Z), sync chain=0, cnt=0, stable=0, prev=0, din_o=0, irq_status_o=0, irq_o=0. Reset mid-operation aborts any pending debounce and drops pending status.
- After reset release a pad held high produces a rising edge (stable 0->1); bench and software clear status after init.
- Output latency: oe_i/dout_i to pad = 1 clk edge.
- Input latency: pad change sampled at edge 1 -> s changes at edge SYNC_STAGES -> stable at edge SYNC_STAGES+DEBOUNCE_CYCLES -> irq_status/irq_o at edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- irq_clr_i is a level per cycle; status clears at next edge unless re-set that cycle.

## Structure
- Package gpio_pkg: default WIDTH/SYNC_STAGES/DEBOUNCE_CYCLES constants, counter-width function (max(1,clog2(n))).
- Sub-module gpio_bit_filter: one pin's synchroniser, debounce counter, stable/prev regs, rise/fall outputs; generate-instantiated WIDTH times. Top holds output regs, IOBUF array, status register, irq OR.

## Test plan
- Reset: assert rst_n=0 mid-traffic with oe_i=FF -> pads high-Z immediately, all outputs 0; release -> pads driven 1 cycle after first edge.
- Drive/readback, WIDTH=8, SYNC=2, DEB=1: oe_i=FF, dout_i=A5 -> pad=A5 after 1 edge, din_o=A5 after 3 more edges.
- Debounce DEB=4, oe=0: pin0 glitch high 3 cycles -> din_o[0] stays 0, no status; high 4 cycles -> din_o[0]=1 at edge 2+4.
- Edges: rise_en=01, fall_en=02; pin0 0->1, pin1 1->0 -> irq_status=03, irq_o=1 at edge SYNC+DEB+1; pin0 1->0 -> no new bit.
- Clear: irq_clr=01 -> status=02; irq_clr=02 same cycle as new pin1 fall -> status[1] stays 1.
- Enable change: status[0]=1, rise_en[0] dropped -> status[0] held until irq_clr[0].
